// File: rtl/dom_share_encoder.sv
// Boolean masking source: splits an unmasked word into SHARES shares using
// fresh randomness gathered over a valid/ready handshake. All outputs are
// registered, so plaintext never reaches the share outputs combinationally.
module dom_share_encoder #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned SHARES = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [WIDTH-1:0]        data_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [WIDTH-1:0]        rnd_i,
  input  logic                    rnd_valid_i,
  output logic                    rnd_ready_o,
  output logic [SHARES*WIDTH-1:0] shares_o,
  output logic                    valid_o,
  input  logic                    ready_i
);

  localparam int unsigned     CntW    = $clog2(SHARES) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(SHARES - 1);

  typedef enum logic [1:0] {StIdle, StGather, StEmit} state_e;

  state_e                  state_q, state_d;
  logic                    ready_q, ready_d;
  logic                    rnd_ready_q, rnd_ready_d;
  logic                    valid_q, valid_d;
  logic [SHARES*WIDTH-1:0] shares_q, shares_d;
  logic [SHARES*WIDTH-1:0] shares_load;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]        acc_q, acc_d;
  logic                    in_hs, rnd_hs, out_hs, last_hs;

  assign in_hs   = valid_i & ready_q;
  assign rnd_hs  = rnd_valid_i & rnd_ready_q;
  assign out_hs  = valid_q & ready_i;
  assign last_hs = rnd_hs & (cnt_q == LastCnt);

  // Middle shares (1..SHARES-2) are parked in slots until the final word arrives.
  if (SHARES > 2) begin : g_slots
    logic [SHARES-2:1][WIDTH-1:0] slot_q, slot_d;

    // Capture each non-final random word into the slot selected by the counter.
    always_comb begin
      slot_d = slot_q;
      for (int k = 1; k < int'(SHARES) - 1; k++) begin
        if (rnd_hs && (cnt_q == CntW'(k))) begin
          slot_d[k] = rnd_i;
        end
      end
    end

    // Slot storage, cleared on reset so aborted randomness is discarded.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        slot_q <= '0;
      end else begin
        slot_q <= slot_d;
      end
    end

    assign shares_load = {rnd_i, slot_q, acc_q ^ rnd_i};
  end else begin : g_no_slots
    assign shares_load = {rnd_i, acc_q ^ rnd_i};
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      ready_q     <= 1'b1;
      rnd_ready_q <= 1'b0;
      valid_q     <= 1'b0;
      shares_q    <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      rnd_ready_q <= rnd_ready_d;
      valid_q     <= valid_d;
      shares_q    <= shares_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (in_hs)   state_d = StGather;
      StGather: if (last_hs) state_d = StEmit;
      StEmit:   if (out_hs)  state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Next values of the registered outputs, accumulator and counter.
  always_comb begin
    ready_d     = ready_q;
    rnd_ready_d = rnd_ready_q;
    valid_d     = valid_q;
    shares_d    = shares_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    unique case (state_q)
      StIdle: begin
        if (in_hs) begin
          acc_d       = data_i;
          cnt_d       = CntW'(1);
          ready_d     = 1'b0;
          rnd_ready_d = 1'b1;
        end
      end
      StGather: begin
        if (last_hs) begin
          // All shares land in one edge; the accumulator is wiped once used.
          shares_d    = shares_load;
          acc_d       = '0;
          cnt_d       = '0;
          valid_d     = 1'b1;
          rnd_ready_d = 1'b0;
        end else if (rnd_hs) begin
          acc_d = acc_q ^ rnd_i;
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StEmit: begin
        if (out_hs) begin
          valid_d = 1'b0;
          ready_d = 1'b1;
        end
      end
      default: begin
        ready_d     = 1'b1;
        rnd_ready_d = 1'b0;
        valid_d     = 1'b0;
        cnt_d       = '0;
        acc_d       = '0;
      end
    endcase
  end

  assign ready_o     = ready_q;
  assign rnd_ready_o = rnd_ready_q;
  assign valid_o     = valid_q;
  assign shares_o    = shares_q;

endmodule

// File: tb/tb_dom_share_encoder.sv
// Bench for dom_share_encoder: directed scenarios on a 2-share and a 3-share
// instance, plus a randomized run of the 3-share instance against a model.
module tb_dom_share_encoder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // SHARES = 2 instance
  logic [7:0]  d2_data, d2_rnd;
  logic        d2_valid, d2_rnd_valid, d2_ready_i;
  logic        d2_ready_o, d2_rnd_ready_o, d2_valid_o;
  logic [15:0] d2_shares;

  // SHARES = 3 instance
  logic [7:0]  d3_data, d3_rnd;
  logic        d3_valid, d3_rnd_valid, d3_ready_i;
  logic        d3_ready_o, d3_rnd_ready_o, d3_valid_o;
  logic [23:0] d3_shares;

  dom_share_encoder #(.WIDTH(8), .SHARES(2)) u_dut2 (
    .clk_i       (clk),
    .rst_i       (rst),
    .data_i      (d2_data),
    .valid_i     (d2_valid),
    .ready_o     (d2_ready_o),
    .rnd_i       (d2_rnd),
    .rnd_valid_i (d2_rnd_valid),
    .rnd_ready_o (d2_rnd_ready_o),
    .shares_o    (d2_shares),
    .valid_o     (d2_valid_o),
    .ready_i     (d2_ready_i)
  );

  dom_share_encoder #(.WIDTH(8), .SHARES(3)) u_dut3 (
    .clk_i       (clk),
    .rst_i       (rst),
    .data_i      (d3_data),
    .valid_i     (d3_valid),
    .ready_o     (d3_ready_o),
    .rnd_i       (d3_rnd),
    .rnd_valid_i (d3_rnd_valid),
    .rnd_ready_o (d3_rnd_ready_o),
    .shares_o    (d3_shares),
    .valid_o     (d3_valid_o),
    .ready_i     (d3_ready_i)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model of the 3-share encoder: phase 0 idle, 1 gathering, 2 emitting.
  int          m_phase = 0;
  logic [7:0]  m_data  = '0;
  logic [7:0]  m_rnds[$];
  logic [23:0] m_last  = '0;
  int          n_acc   = 0;
  int          n_words = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xor3(input logic [23:0] s);
    return s[7:0] ^ s[15:8] ^ s[23:16];
  endfunction

  // One clock of the 3-share instance: check outputs against the model, then advance it.
  task automatic tick3();
    @(negedge clk);
    check("d3 ready_o", d3_ready_o, m_phase == 0);
    check("d3 rnd_ready_o", d3_rnd_ready_o, m_phase == 1);
    check("d3 valid_o", d3_valid_o, m_phase == 2);
    check("d3 shares_o", d3_shares, m_last);
    case (m_phase)
      0: if (d3_valid) begin
        m_data = d3_data;
        m_rnds.delete();
        m_phase = 1;
        n_acc++;
      end
      1: if (d3_rnd_valid) begin
        m_rnds.push_back(d3_rnd);
        if (m_rnds.size() == 2) begin
          m_last  = {m_rnds[1], m_rnds[0], m_data ^ m_rnds[0] ^ m_rnds[1]};
          m_phase = 2;
        end
      end
      default: if (d3_ready_i) begin
        check("d3 xor invariant", xor3(d3_shares), m_data);
        m_phase = 0;
        n_words++;
      end
    endcase
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    {d2_data, d2_rnd, d2_valid, d2_rnd_valid, d2_ready_i} = '0;
    {d3_data, d3_rnd, d3_valid, d3_rnd_valid, d3_ready_i} = '0;
    #12;
    // Reset state
    check("rst d2 ready_o", d2_ready_o, 1);
    check("rst d2 rnd_ready_o", d2_rnd_ready_o, 0);
    check("rst d2 valid_o", d2_valid_o, 0);
    check("rst d2 shares_o", d2_shares, 0);
    check("rst d3 ready_o", d3_ready_o, 1);
    check("rst d3 valid_o", d3_valid_o, 0);
    check("rst d3 shares_o", d3_shares, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // SHARES=2: A5 with rnd 3C always valid, ready_i high
    d2_valid = 1'b1; d2_data = 8'hA5; d2_rnd_valid = 1'b1; d2_rnd = 8'h3C; d2_ready_i = 1'b1;
    @(posedge clk); #1;
    d2_valid = 1'b0;
    check("s2 accept ready_o", d2_ready_o, 0);
    check("s2 accept rnd_ready_o", d2_rnd_ready_o, 1);
    check("s2 accept valid_o", d2_valid_o, 0);
    @(posedge clk); #1;
    check("s2 valid_o", d2_valid_o, 1);
    check("s2 rnd_ready_o", d2_rnd_ready_o, 0);
    check("s2 shares_o", d2_shares, 16'h3C99);
    check("s2 xor", d2_shares[7:0] ^ d2_shares[15:8], 8'hA5);
    @(posedge clk); #1;
    check("s2 after xfer valid_o", d2_valid_o, 0);
    check("s2 after xfer ready_o", d2_ready_o, 1);
    check("s2 shares held", d2_shares, 16'h3C99);
    {d2_data, d2_rnd, d2_valid, d2_rnd_valid, d2_ready_i} = '0;

    // SHARES=3: FF with rnd 0F, F0 (rnd_valid high in idle must be ignored)
    d3_valid = 1'b1; d3_data = 8'hFF; d3_rnd_valid = 1'b1; d3_rnd = 8'h0F;
    tick3();
    d3_valid = 1'b0;
    tick3();
    d3_rnd = 8'hF0;
    tick3();
    check("s3 shares", d3_shares, 24'hF00F00);
    d3_rnd_valid = 1'b0; d3_ready_i = 1'b1;
    tick3();

    // RNG stall for 5 cycles, then backpressure for 4 cycles in emit
    d3_valid = 1'b1; d3_data = 8'h5A;
    tick3();
    d3_valid = 1'b0;
    repeat (5) tick3();
    d3_rnd_valid = 1'b1; d3_rnd = 8'h11;
    tick3();
    d3_rnd = 8'h22;
    tick3();
    d3_rnd_valid = 1'b0; d3_ready_i = 1'b0;
    repeat (4) tick3();
    check("bp shares", d3_shares, {8'h22, 8'h11, 8'h5A ^ 8'h11 ^ 8'h22});
    d3_ready_i = 1'b1;
    tick3();
    check("bp ready_o after xfer", d3_ready_o, 1);

    // Reset in the middle of gathering, after one random word
    d3_valid = 1'b1; d3_data = 8'h77;
    tick3();
    d3_valid = 1'b0; d3_rnd_valid = 1'b1; d3_rnd = 8'h99;
    tick3();
    rst = 1'b1;
    #1;
    check("midrst ready_o", d3_ready_o, 1);
    check("midrst rnd_ready_o", d3_rnd_ready_o, 0);
    check("midrst valid_o", d3_valid_o, 0);
    check("midrst shares_o", d3_shares, 0);
    @(negedge clk);
    rst = 1'b0;
    m_phase = 0; m_last = '0; m_rnds.delete();
    @(posedge clk); #1;
    d3_valid = 1'b1; d3_data = 8'h12; d3_rnd_valid = 1'b0;
    tick3();
    d3_valid = 1'b0; d3_rnd_valid = 1'b1; d3_rnd = 8'h34;
    tick3();
    d3_rnd = 8'h56;
    tick3();
    check("after rst shares", d3_shares, 24'h563470);
    d3_rnd_valid = 1'b0; d3_ready_i = 1'b1;
    tick3();

    // Randomized traffic: 256 words with random gaps on every handshake
    n_acc = 0; n_words = 0;
    for (int c = 0; c < 20000 && n_words < 256; c++) begin
      d3_valid     = ($urandom_range(0, 9) < 7);
      d3_data      = 8'($urandom);
      d3_rnd_valid = ($urandom_range(0, 9) < 6);
      d3_rnd       = 8'($urandom);
      d3_ready_i   = ($urandom_range(0, 9) < 6);
      tick3();
    end
    check("rand words transferred", n_words, 256);
    check("rand words accepted", n_acc, 256);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dom_share_encoder.md
Name: dom_share_encoder

Overview:
- Converts an unmasked WIDTH-bit word into SHARES Boolean shares using fresh randomness pulled over a handshake.
- The source side of the masked datapath: it produces the X/Y share sets consumed by the DOM AND gadgets.
- share0 = data ^ r1 ^ ... ^ r(SHARES-1); share k = rk for k ≥ 1.
- All outputs are registered, so no combinational path mixes plaintext with the output shares.

Parameters:
WIDTH, 8, bit width of the data word and of each share
SHARES, 2, number of output shares (legal 2..4; 2 = first order)

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  reset, asynchronous, active-high
data_i  input  WIDTH  unmasked input word
valid_i  input  1  data_i valid
ready_o  output  1  encoder can accept data_i
rnd_i  input  WIDTH  fresh random word from RNG
rnd_valid_i  input  1  rnd_i valid
rnd_ready_o  output  1  encoder consumes rnd_i this cycle
shares_o  output  SHARES*WIDTH  share k at bits [k*WIDTH +: WIDTH]
valid_o  output  1  shares_o valid
ready_i  input  1  downstream accepts shares_o

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is asynchronous and active-high.
- Reset values: state=IDLE, ready_o=1, rnd_ready_o=0, valid_o=0, shares_o=0, counter=0, accumulator=0. Asserting rst_i mid-operation aborts the operation immediately; the partly gathered randomness and the accumulator are discarded and cleared.
- States: IDLE, GATHER, EMIT. Handshakes are standard valid/ready; a transfer occurs on a rising edge where both are high.
- IDLE:
  - ready_o=1, rnd_ready_o=0, valid_o=0.
  - On valid_i&&ready_o: acc<=data_i, cnt<=1, go to GATHER.
  - ready_o is registered and drops in the cycle after acceptance.
- GATHER:
  - ready_o=0, rnd_ready_o=1.
  - On each rnd handshake: slot[cnt]<=rnd_i, acc<=acc^rnd_i, cnt<=cnt+1.
  - Cycles with rnd_valid_i=0 stall with no state change.
  - The handshake with cnt==SHARES-1 is the last one: in that same cycle load the output registers atomically: shares_o[0]<=acc^rnd_i, shares_o[k]<=slot[k] for 1≤k<SHARES-1, shares_o[SHARES-1]<=rnd_i. Then valid_o<=1, rnd_ready_o<=0, go to EMIT.
- EMIT:
  - valid_o=1, and shares_o is held stable until the transfer.
  - On ready_i: valid_o<=0, ready_o<=1, go to IDLE.
  - shares_o keeps its last value after valid_o falls.
  - No new input is accepted in EMIT (no overlap); throughput is one word per SHARES+1 cycles minimum.
- Latency with no stalls: input accepted at edge t, random words consumed at edges t+1..t+SHARES-1, valid_o high after edge t+SHARES-1.
- Randomness:
  - Each random word is used exactly once and never reused across words.
  - rnd_i is ignored whenever rnd_ready_o=0.
  - The accumulator is internal only and never drives an output directly.
- Width rules: all XORs are WIDTH bits wide; cnt is $clog2(SHARES)+1 bits and never wraps (range 1..SHARES-1).
- Simultaneous events: valid_i during GATHER/EMIT is ignored, so the upstream must hold it. rnd_valid_i high in IDLE/EMIT is ignored.
- Invariant checked by the bench: XOR of all shares == accepted data_i at every valid_o transfer.

Test Plan:
- SHARES=2, data_i=0xA5, rnd_i=0x3C always valid, ready_i=1 → valid_o after 2 edges; shares_o[7:0]=0x99, [15:8]=0x3C; XOR=0xA5.
- SHARES=3, data_i=0xFF, rnd sequence 0x0F,0xF0 → share0=0x00, share1=0x0F, share2=0xF0; rnd_ready_o high for exactly 2 handshakes.
- RNG stall: rnd_valid_i low for 5 cycles after acceptance → no state change, valid_o stays 0; resumes correctly once valid; latency extends by 5.
- Backpressure: ready_i=0 for 4 cycles in EMIT → shares_o stable and valid_o held, ready_o=0; transfer on the first ready_i=1, ready_o=1 next cycle.
- Reset mid-GATHER (SHARES=3, after 1 rnd word) → all outputs 0 and ready_o=1 immediately; next word 0x12 with rnd 0x34,0x56 → share0=0x70.
- Back-to-back: 256 random words with random rnd_i and random valid/ready gaps → XOR of shares == data_i for every transfer, no lost or duplicated word.
